ternary_alu_arbiter: RTL

- Shares one ternary_alu (registered, 9-trit) between two requesters (req0, req1).
- Round-robin arbitration, one operation in flight at a time, per-requester valid/ready request and response channels.
- Rejects malformed opcodes without issuing them to the ALU.
- Sits between the decode/issue stages and the ALU instance.

---
 rtl/ternary_alu_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/ternary_alu_arbiter.sv
// Round-robin arbiter sharing one registered ternary ALU between two requesters.
// Malformed opcodes are answered with an error response and never reach the ALU.
module ternary_alu_arbiter #(
    parameter int WORD_SIZE = 9,
    parameter int CNT_W     = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [5:0]             req0_opcode,
    input  logic [2*WORD_SIZE-1:0] req0_a,
    input  logic [2*WORD_SIZE-1:0] req0_b,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [5:0]             req1_opcode,
    input  logic [2*WORD_SIZE-1:0] req1_a,
    input  logic [2*WORD_SIZE-1:0] req1_b,
    output logic                   rsp0_valid,
    input  logic                   rsp0_ready,
    output logic                   rsp1_valid,
    input  logic                   rsp1_ready,
    output logic [2*WORD_SIZE-1:0] rsp_data,
    output logic                   rsp_err,
    output logic [5:0]             alu_opcode,
    output logic [2*WORD_SIZE-1:0] alu_input1,
    output logic [2*WORD_SIZE-1:0] alu_input2,
    output logic                   alu_enable,
    input  logic [2*WORD_SIZE-1:0] alu_out,
    output logic                   busy,
    output logic [CNT_W-1:0]       op_count
);

    localparam int DW = 2 * WORD_SIZE;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESP
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic            rr_ptr;
    logic            gnt_id;
    logic            gnt0;
    logic            gnt1;
    logic            req_hs;
    logic            rsp_hs;
    logic            sel_legal;
    logic [5:0]      sel_op;
    logic [DW-1:0]   sel_a;
    logic [DW-1:0]   sel_b;

    function automatic logic op_legal(input logic [5:0] op);
        logic ok;
        case (op)
            6'b000000, 6'b000011, 6'b000101, 6'b000111,
            6'b001100, 6'b001101, 6'b001111, 6'b010011,
            6'b010100, 6'b010101, 6'b010111, 6'b011100: ok = 1'b1;
            default:                                    ok = 1'b0;
        endcase
        return ok;
    endfunction

    always_comb begin
        gnt0       = req0_valid && (!rr_ptr || !req1_valid);
        gnt1       = req1_valid && !gnt0;
        req0_ready = (state == IDLE) && !reset && gnt0;
        req1_ready = (state == IDLE) && !reset && gnt1;
        req_hs     = req0_ready || req1_ready;
        sel_op     = gnt1 ? req1_opcode : req0_opcode;
        sel_a      = gnt1 ? req1_a : req0_a;
        sel_b      = gnt1 ? req1_b : req0_b;
        sel_legal  = op_legal(sel_op);
        rsp0_valid = (state == RESP) && !gnt_id;
        rsp1_valid = (state == RESP) && gnt_id;
        rsp_hs     = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
        alu_enable = (state == ISSUE);
        busy       = (state != IDLE);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req_hs) begin
                    state_nx = sel_legal ? ISSUE : RESP;
                end
            end
            ISSUE:   state_nx = CAPTURE;
            CAPTURE: state_nx = RESP;
            RESP: begin
                if (rsp_hs) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= 1'b0;
            gnt_id     <= 1'b0;
            alu_opcode <= '0;
            alu_input1 <= '0;
            alu_input2 <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            op_count   <= '0;
        end else begin
            state <= state_nx;
            if (req_hs) begin
                gnt_id     <= gnt1;
                alu_opcode <= sel_op;
                alu_input1 <= sel_a;
                alu_input2 <= sel_b;
                if (!sel_legal) begin
                    rsp_data <= '0;
                    rsp_err  <= 1'b1;
                end
            end
            if (state == CAPTURE) begin
                rsp_data <= alu_out;
                rsp_err  <= 1'b0;
            end
            // Winner of this round yields priority to the other requester.
            if (rsp_hs) begin
                op_count <= op_count + 1'b1;
                rr_ptr   <= ~gnt_id;
            end
        end
    end

endmodule
